apb_mem_bridge: RTL and testbench

// - APB3 completer that turns each APB transfer into one simple-memory request (req/rnw/addr/wdata, ready/rdata).
// - It is the initiator side of the simple-memory interface, sitting between the APB fabric and the 16x32 register memory.
// - It inserts wait states until the memory handshakes, and flags bad accesses with PSLVERR.

---
 rtl/apb_mem_bridge.sv | 135 +++++++++++++
 tb/tb_apb_mem_bridge.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_mem_bridge.sv
// APB3 completer bridging each transfer to one simple-memory request, with PSLVERR on bad addresses.
// Optional REQ-phase timeout abort enabled by defining APB_MEM_BRIDGE_TIMEOUT_EN.
module apb_mem_bridge #(
  parameter int unsigned ADDR_W         = 4,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned PADDR_W        = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               psel,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [PADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0]  pwdata,
  output logic               pready,
  output logic [DATA_W-1:0]  prdata,
  output logic               pslverr,
  output logic               req_o,
  output logic               req_rnw_o,
  output logic [ADDR_W-1:0]  req_addr_o,
  output logic [DATA_W-1:0]  req_wdata_o,
  input  logic               req_ready_i,
  input  logic [DATA_W-1:0]  req_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_e;

  state_e              state_q, state_d;
  logic                setup_c, bad_addr_c, hs_c, timeout_c;
  logic                pready_d, pslverr_d, req_d, rnw_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   wdata_d, prdata_d;

  assign setup_c    = psel & ~penable;
  assign bad_addr_c = (paddr[1:0] != 2'b00) | (paddr[PADDR_W-1:ADDR_W+2] != '0);
  assign hs_c       = req_o & req_ready_i;

`ifdef APB_MEM_BRIDGE_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Cycles spent in REQ; zero on entry, cleared whenever REQ is left.
  always_comb begin
    cnt_d = '0;
    if (state_q == REQ && state_d == REQ) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign timeout_c = (state_q == REQ) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_c;
  assign unused_timeout_c = (TIMEOUT_CYCLES != 0);
  assign timeout_c        = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: a handshake wins over an abort or a timeout in the same cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (setup_c) state_d = bad_addr_c ? ERR : REQ;
      REQ: begin
        if (hs_c)           state_d = RESP;
        else if (!psel)     state_d = IDLE;
        else if (timeout_c) state_d = ERR;
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output next values; the error response leaves ERR one cycle after the decode
  always_comb begin
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = prdata;
    req_d     = (state_d == REQ);
    rnw_d     = req_rnw_o;
    addr_d    = req_addr_o;
    wdata_d   = req_wdata_o;
    unique case (state_q)
      IDLE: begin
        if (setup_c) begin
          rnw_d   = ~pwrite;
          addr_d  = paddr[ADDR_W+1:2];
          wdata_d = pwdata;
        end
      end
      REQ: begin
        if (hs_c) begin
          pready_d = 1'b1;
          if (req_rnw_o) prdata_d = req_rdata_i;
        end
      end
      ERR: begin
        pready_d  = 1'b1;
        pslverr_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pready      <= 1'b0;
      pslverr     <= 1'b0;
      prdata      <= '0;
      req_o       <= 1'b0;
      req_rnw_o   <= 1'b1;
      req_addr_o  <= '0;
      req_wdata_o <= '0;
    end else begin
      pready      <= pready_d;
      pslverr     <= pslverr_d;
      prdata      <= prdata_d;
      req_o       <= req_d;
      req_rnw_o   <= rnw_d;
      req_addr_o  <= addr_d;
      req_wdata_o <= wdata_d;
    end
  end

endmodule

// File: tb/tb_apb_mem_bridge.sv
// Scoreboard bench for apb_mem_bridge: APB master, 16x32 memory responder and a reference model.
module tb_apb_mem_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic        pready, pslverr;
  logic [31:0] prdata;
  logic        req_o, req_rnw_o;
  logic [3:0]  req_addr_o;
  logic [31:0] req_wdata_o;
  logic        req_ready_i;
  logic [31:0] req_rdata_i;

  always #5 clk = ~clk;

  apb_mem_bridge dut (
    .clk(clk), .reset(reset),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .prdata(prdata), .pslverr(pslverr),
    .req_o(req_o), .req_rnw_o(req_rnw_o), .req_addr_o(req_addr_o), .req_wdata_o(req_wdata_o),
    .req_ready_i(req_ready_i), .req_rdata_i(req_rdata_i)
  );

  // Memory responder: ready raised mem_wait cycles after req is seen, write committed on handshake
  logic [31:0] mem [16];
  logic        mem_rdy;
  int          mem_cnt;
  int          mem_wait = 0;
  bit          mem_en   = 1'b1;

  always @(posedge clk) begin
    if (reset) begin
      mem_rdy <= 1'b0;
      mem_cnt <= 0;
    end else if (req_o && mem_rdy) begin
      if (!req_rnw_o) mem[req_addr_o] <= req_wdata_o;
      mem_rdy <= 1'b0;
      mem_cnt <= 0;
    end else if (req_o && mem_en) begin
      if (mem_cnt >= mem_wait) mem_rdy <= 1'b1;
      else                     mem_cnt <= mem_cnt + 1;
    end else begin
      mem_rdy <= 1'b0;
      mem_cnt <= 0;
    end
  end

  assign req_ready_i = mem_rdy;
  assign req_rdata_i = mem[req_addr_o];

  typedef struct {
    bit          err;
    bit          rnw;
    logic [3:0]  idx;
    logic [31:0] wdata;
    logic [31:0] prdata;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [16];
  logic [31:0] ref_prdata = '0;
  int          vectors = 0;
  int          errs    = 0;
  int          req_hi  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on pready and checks every memory handshake
  task automatic monitor();
    int   cyc = 0;
    int   setup_cyc = 0;
    bit   pready_prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        pready_prev = 1'b0;
      end else begin
        if (psel && !penable) setup_cyc = cyc;
        if (req_o) req_hi++;
        if (req_o && req_ready_i) begin
          if (sb.size() == 0) begin
            chk("hs_unexpected", 32'(req_o & req_ready_i), 32'd0);
          end else begin
            e = sb[0];
            chk("hs_allowed", 32'(req_o & req_ready_i), 32'(!e.err));
            chk("hs_rnw", 32'(req_rnw_o), 32'(e.rnw));
            chk("hs_addr", 32'(req_addr_o), 32'(e.idx));
            if (!e.rnw) chk("hs_wdata", req_wdata_o, e.wdata);
          end
        end
        if (pready) begin
          chk("pready_single", 32'(pready_prev), 32'd0);
          if (sb.size() == 0) begin
            chk("pready_unexpected", 32'(pready), 32'd0);
          end else begin
            e = sb.pop_front();
            chk("pslverr", 32'(pslverr), 32'(e.err));
            chk("prdata", prdata, e.prdata);
            chk("latency", 32'(cyc - setup_cyc), 32'(e.lat));
          end
        end
        pready_prev = pready;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One APB transfer; expectations derived from address arithmetic and the word array
  task automatic apb_xfer(input bit wr, input logic [31:0] a, input logic [31:0] d, input int w);
    exp_t e;
    int   n;
    int   exp_req;
    bit   bad;
    bad     = (a % 4 != 0) || (a >= 32'd64);
    e.err   = bad || !mem_en;
    e.rnw   = !wr;
    e.idx   = 4'(a / 4);
    e.wdata = d;
    if (!e.err && wr)  ref_mem[a / 4] = d;
    if (!e.err && !wr) ref_prdata = ref_mem[a / 4];
    e.prdata = ref_prdata;
    e.lat    = bad ? 2 : (mem_en ? 3 + w : 18);
    exp_req  = bad ? 0 : (mem_en ? 2 + w : 16);
    sb.push_back(e);
    mem_wait = w;
    req_hi   = 0;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge clk);
    #1 penable = 1'b1;
    n = 0;
    while (!pready && n < 64) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 64) begin
      chk("pready_timeout", 32'(pready), 32'd1);
    end else begin
      @(posedge clk);
      #1;
    end
    psel = 1'b0; penable = 1'b0;
    chk("req_cycles", 32'(req_hi), 32'(exp_req));
  endtask

  initial begin
    reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_pready", 32'(pready), 32'd0);
    chk("rst_pslverr", 32'(pslverr), 32'd0);
    chk("rst_prdata", prdata, 32'd0);
    chk("rst_req", 32'(req_o), 32'd0);
    chk("rst_rnw", 32'(req_rnw_o), 32'd1);
    chk("rst_addr", 32'(req_addr_o), 32'd0);
    chk("rst_wdata", req_wdata_o, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1 chk("req_after_release", 32'(req_o), 32'd0);

    apb_xfer(1'b1, 32'h14, 32'hDEADBEEF, 0);
    apb_xfer(1'b0, 32'h14, 32'h0, 0);
    apb_xfer(1'b0, 32'h02, 32'h0, 0);
    apb_xfer(1'b0, 32'h40, 32'h0, 0);

    for (int i = 0; i < 16; i++) apb_xfer(1'b1, 32'(i * 4), 32'(i) * 32'h01010101, 0);
    for (int i = 0; i < 16; i++) apb_xfer(1'b0, 32'(i * 4), $urandom, 0);

    // Reset while the request is outstanding
    mem_en = 1'b0;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8; pwdata = $urandom;
    @(posedge clk);
    #1 penable = 1'b1;
    @(posedge clk);
    #1 chk("req_in_req", 32'(req_o), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("req_after_rst", 32'(req_o), 32'd0);
    chk("pready_after_rst", 32'(pready), 32'd0);
    reset = 1'b0; psel = 1'b0; penable = 1'b0;
    ref_prdata = '0;
    mem_en = 1'b1;
    idle(1);
    apb_xfer(1'b0, 32'h8, 32'h0, 0);

`ifdef APB_MEM_BRIDGE_TIMEOUT_EN
    mem_en = 1'b0;
    apb_xfer(1'b0, 32'h10, 32'h0, 0);
    mem_en = 1'b1;
`endif

    for (int i = 0; i < 200; i++) begin
      int          r;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      if (r == 0)      a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      else if (r == 1) a = ($urandom | 32'h40) & 32'hFFFF_FFFC;
      else             a = 32'($urandom_range(0, 15) * 4);
      apb_xfer(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    idle(4);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
